// File: rtl/a2d_spi_pkg.sv
// Shared types and frame geometry for the A2D SPI responder.
package a2d_spi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SHIFT   = 2'd2,
    WAIT_HI = 2'd3
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int CH_MSB     = 13;
  localparam int CH_LSB     = 11;
  localparam int DATA_W     = 12;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

endpackage

// File: rtl/a2d_spi_resp_if.sv
// SPI pins between the A2D initiator (master) and this responder (slave).
interface a2d_spi_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer for one asynchronous SPI pin with rise/fall pulses
// taken between flops 2 and 3.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= {3{RST_VAL}};
    else     sync_q <= {sync_q[1:0], din};
  end

  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder for the A2D: decodes the channel command and shifts back the
// sample captured at the start of each frame.
//
// state   | meaning
// IDLE    | SS_n high, waiting for a frame to start
// LOAD    | one clk: capture smpl into tx_shft, clear counters
// SHIFT   | frame active, shifting on synchronized SCLK edges
// WAIT_HI | after reset, waiting for SS_n to be seen high before decoding
module a2d_spi_resp
  import a2d_spi_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  a2d_spi_resp_if.slave            spi,
  input  logic [DATA_W-1:0]        smpl,
  output logic [CH_MSB-CH_LSB:0]   chnl,
  output logic                     ch_req,
  output logic                     frm_err
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_BITS);

  state_t                  state, state_nxt;
  logic                    ss_rise, ss_fall, sclk_rise, sclk_fall;
  logic [1:0]              mosi_sync;
  logic                    ss_high;
  logic [1:0]              wait_cnt;
  logic [FRAME_BITS-1:0]   tx_shft, rx_shft;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    miso;

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .din(spi.SS_n), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(spi.SCLK), .rise(sclk_rise), .fall(sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_HI;
    else     state <= state_nxt;
  end

  // The synchronizer comes out of reset reading "high", so WAIT_HI needs a few
  // genuine high samples before trusting it; a frame live at release is skipped.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_HI: if (ss_high && !ss_fall && wait_cnt == 2'd0) state_nxt = IDLE;
      IDLE:    if (ss_fall) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (ss_rise) state_nxt = IDLE;
      default: state_nxt = WAIT_HI;
    endcase
  end

  always_comb begin
    miso = 1'b0;
    if ((state == LOAD || state == SHIFT) && bit_cnt != FULL) miso = tx_shft[FRAME_BITS-1];
  end

  assign spi.MISO = miso;

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync <= 2'b00;
      ss_high   <= 1'b1;
      wait_cnt  <= 2'd3;
      tx_shft   <= '0;
      rx_shft   <= '0;
      bit_cnt   <= '0;
      chnl      <= '0;
      ch_req    <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      mosi_sync <= {mosi_sync[0], spi.MOSI};
      ch_req    <= 1'b0;
      frm_err   <= 1'b0;
      if (ss_rise)      ss_high <= 1'b1;
      else if (ss_fall) ss_high <= 1'b0;

      if (state == WAIT_HI) begin
        if (ss_fall)                        wait_cnt <= 2'd3;
        else if (ss_high && wait_cnt != 0)  wait_cnt <= wait_cnt - 2'd1;
      end

      case (state)
        LOAD: begin
          tx_shft <= {{(FRAME_BITS-DATA_W){1'b0}}, smpl};
          rx_shft <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          // An SS_n rise takes priority over any SCLK edge in the same clk.
          if (ss_rise) begin
            if (bit_cnt == FULL) begin
              chnl   <= rx_shft[CH_MSB:CH_LSB];
              ch_req <= 1'b1;
            end else begin
              frm_err <= 1'b1;
            end
          end else if (bit_cnt != FULL) begin
            if (sclk_rise) begin
              rx_shft <= {rx_shft[FRAME_BITS-2:0], mosi_sync[1]};
              bit_cnt <= bit_cnt + 1'b1;
            end else if (sclk_fall) begin
              tx_shft <= {tx_shft[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp: table of full/odd-length frames plus
// hand-built back-to-back and reset-mid-frame sequences.
module tb_a2d_spi_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] smpl;
  logic [2:0]  chnl;
  logic        ch_req;
  logic        frm_err;

  a2d_spi_resp_if spi_bus ();

  a2d_spi_resp dut (
    .clk(clk), .rst(rst), .spi(spi_bus), .smpl(smpl),
    .chnl(chnl), .ch_req(ch_req), .frm_err(frm_err)
  );

  always #10 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Pulse monitor: cumulative counts, the stimulus takes snapshots.
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  logic [2:0] creq_log[$];

  always @(negedge clk) begin
    if (ch_req) creq_log.push_back(chnl);
    if (frm_err) ferr_cnt++;
    if (ch_req && frm_err) both_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic sclk_bit(input logic b, output logic m);
    spi_bus.MOSI = b;
    repeat (16) @(negedge clk);
    spi_bus.SCLK = 1'b1;
    m = spi_bus.MISO;
    repeat (16) @(negedge clk);
    spi_bus.SCLK = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] cmd, input int nclk,
                           output logic [15:0] resp, output int extra_ones);
    logic m;
    resp = '0;
    extra_ones = 0;
    spi_bus.SS_n = 1'b0;
    for (int i = 0; i < nclk; i++) begin
      sclk_bit((i < 16) ? cmd[15-i] : 1'b0, m);
      if (i < 16) resp[15-i] = m;
      else if (m) extra_ones++;
    end
    repeat (16) @(negedge clk);
    spi_bus.SS_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] cmd;
    int          nclk;
    logic [11:0] smpl;
    logic [2:0]  exp_ch;
    logic [15:0] exp_miso;
    logic        chk_miso;
    int          exp_creq;
    int          exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] resp;
    int          extra;
    int          base_q, base_f;
    logic        m;
    logic [15:0] cmd7;

    vecs[0] = '{16'h1800, 16, 12'hABC, 3'd3, 16'h0ABC, 1'b1, 1, 0};
    vecs[1] = '{16'h2800, 16, 12'hABC, 3'd5, 16'h0ABC, 1'b1, 1, 0};
    vecs[2] = '{16'h3000,  9, 12'h123, 3'd5, 16'h0000, 1'b0, 0, 1};
    vecs[3] = '{16'h1000, 20, 12'hFFF, 3'd2, 16'h0FFF, 1'b1, 1, 0};
    vecs[4] = '{16'hC7FF, 16, 12'h5A5, 3'd0, 16'h05A5, 1'b1, 1, 0};
    vecs[5] = '{16'h3800, 16, 12'h000, 3'd7, 16'h0000, 1'b1, 1, 0};

    rst = 1'b1;
    smpl = '0;
    spi_bus.SS_n = 1'b1;
    spi_bus.SCLK = 1'b0;
    spi_bus.MOSI = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_chnl",    32'(chnl),        32'd0);
    check("rst_ch_req",  32'(ch_req),      32'd0);
    check("rst_frm_err", 32'(frm_err),     32'd0);
    check("rst_miso",    32'(spi_bus.MISO), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      smpl   = vecs[i].smpl;
      base_q = creq_log.size();
      base_f = ferr_cnt;
      run_frame(vecs[i].cmd, vecs[i].nclk, resp, extra);
      repeat (24) @(negedge clk);
      check($sformatf("v%0d_chnl", i),    32'(chnl), 32'(vecs[i].exp_ch));
      check($sformatf("v%0d_ch_req", i),  32'(creq_log.size() - base_q), 32'(vecs[i].exp_creq));
      check($sformatf("v%0d_frm_err", i), 32'(ferr_cnt - base_f), 32'(vecs[i].exp_ferr));
      if (vecs[i].exp_creq == 1 && creq_log.size() > base_q)
        check($sformatf("v%0d_req_chnl", i), 32'(creq_log[base_q]), 32'(vecs[i].exp_ch));
      if (vecs[i].chk_miso)
        check($sformatf("v%0d_miso", i), 32'(resp), 32'(vecs[i].exp_miso));
      check($sformatf("v%0d_extra_miso", i), 32'(extra), 32'd0);
      repeat (8) @(negedge clk);
    end

    // Back-to-back frames separated by a 2-clk SS_n high gap.
    smpl   = 12'h246;
    base_q = creq_log.size();
    base_f = ferr_cnt;
    run_frame(16'h2000, 16, resp, extra);
    repeat (2) @(negedge clk);
    run_frame(16'h3000, 16, resp, extra);
    repeat (24) @(negedge clk);
    check("b2b_ch_req_cnt", 32'(creq_log.size() - base_q), 32'd2);
    if (creq_log.size() >= base_q + 2) begin
      check("b2b_first_chnl",  32'(creq_log[base_q]),     32'd4);
      check("b2b_second_chnl", 32'(creq_log[base_q + 1]), 32'd6);
    end
    check("b2b_chnl",    32'(chnl),              32'd6);
    check("b2b_frm_err", 32'(ferr_cnt - base_f), 32'd0);
    check("b2b_miso",    32'(resp),              32'h0246);
    repeat (8) @(negedge clk);

    // Reset at bit 8 of a ch=7 frame, released while SS_n is still low.
    smpl   = 12'h0F0;
    cmd7   = 16'h3800;
    base_q = creq_log.size();
    base_f = ferr_cnt;
    spi_bus.SS_n = 1'b0;
    for (int i = 0; i < 8; i++) sclk_bit(cmd7[15-i], m);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("midrst_chnl_cleared", 32'(chnl), 32'd0);
    for (int i = 8; i < 16; i++) sclk_bit(cmd7[15-i], m);
    repeat (16) @(negedge clk);
    spi_bus.SS_n = 1'b1;
    repeat (24) @(negedge clk);
    check("midrst_ch_req",  32'(creq_log.size() - base_q), 32'd0);
    check("midrst_frm_err", 32'(ferr_cnt - base_f),       32'd0);
    check("midrst_chnl",    32'(chnl),                    32'd0);

    smpl   = 12'h321;
    base_q = creq_log.size();
    run_frame(16'h0800, 16, resp, extra);
    repeat (24) @(negedge clk);
    check("postrst_chnl",   32'(chnl),                    32'd1);
    check("postrst_ch_req", 32'(creq_log.size() - base_q), 32'd1);
    check("postrst_miso",   32'(resp),                    32'h0321);

    check("no_overlap", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/a2d_spi_resp.md
A2D_SPI_RESP -- requirements
Module: a2d_spi_resp

Interface
REQ-001 clk  input  1  system clock, 50 MHz; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset; sampled on rising clk only.
REQ-003 SS_n  input  1  SPI slave select from A2D initiator, active low, asynchronous to clk.
REQ-004 SCLK  input  1  SPI clock, mode 0, nominal clk/32, asynchronous to clk.
REQ-005 MOSI  input  1  serial command from initiator, MSB first.
REQ-006 MISO  output  1  serial response to initiator, MSB first.
REQ-007 smpl  input  12  conversion value supplied by the environment for channel chnl.
REQ-008 chnl  output  3  channel latched from the last complete command frame.
REQ-009 ch_req  output  1  one-clk pulse when chnl is updated.
REQ-010 frm_err  output  1  one-clk pulse when a frame is aborted.

Function
REQ-011 Frame: 16 SCLK periods bounded by SS_n low; MOSI command word = {2'b00, ch[2:0], 11'h000}; MISO response = {4'h0, data[11:0]}.
REQ-012 SS_n, SCLK, MOSI: three-flop synchronizer; edges detected on flops 2/3; MOSI taken from flop 2; total input latency 2 clk.
REQ-013 FSM states: IDLE, LOAD, SHIFT, WAIT_HI.
REQ-014 IDLE -> LOAD on synchronized SS_n fall; otherwise stay.
REQ-015 LOAD (1 clk): tx_shft <= {4'h0, smpl}; bit_cnt <= 0; rx_shft <= 0; -> SHIFT.
REQ-016 SHIFT: on each synchronized SCLK rise, rx_shft <= {rx_shft[14:0], MOSI}; bit_cnt += 1, saturating at 16.
REQ-017 SHIFT: on each synchronized SCLK fall, tx_shft <= {tx_shft[14:0], 1'b0}, only while bit_cnt < 16.
REQ-018 MISO = tx_shft[15] in LOAD/SHIFT; MISO = 0 in IDLE and WAIT_HI.
REQ-019 SHIFT, on SS_n rise with bit_cnt == 16: chnl <= rx_shft[13:11]; ch_req pulses the same cycle chnl changes; -> IDLE.
REQ-020 SHIFT, on SS_n rise with bit_cnt < 16: chnl unchanged, no ch_req, frm_err pulses 1 clk; -> IDLE.
REQ-021 SCLK edges beyond the 16th are ignored: rx_shft frozen, MISO 0, no error.
REQ-022 Response is pipelined one frame: MISO data of frame N is smpl captured at LOAD of frame N; the environment drives smpl for chnl set by frame N-1.
REQ-023 Nonzero rx_shft[15:14] or rx_shft[10:0] still latches channel (don't-care bits).
REQ-024 SCLK edge and SS_n rise in the same clk: SS_n rise wins; the edge is discarded.
REQ-025 ch_req and frm_err are never high in the same cycle.

Reset
REQ-026 On rst: state = WAIT_HI, chnl = 3'b000, ch_req = 0, frm_err = 0, MISO = 0, tx_shft = 0, rx_shft = 0, bit_cnt = 0, synchronizer flops = 1 (SS_n, SCLK) and 0 (MOSI).
REQ-027 WAIT_HI -> IDLE only after synchronized SS_n is seen high; a frame already in progress at reset release is never decoded and never flags frm_err.
REQ-028 rst asserted mid-frame discards the frame with no ch_req or frm_err.

Structure
REQ-029 Package a2d_spi_pkg holds state enum, FRAME_BITS = 16, CH_MSB = 13, CH_LSB = 11, DATA_W = 12.
REQ-030 One sub-module, spi_sync_edge: 3-flop synchronizer plus rise/fall pulse for one signal, instantiated for SS_n and SCLK.
REQ-031 Target size is 150-250 lines of RTL; no latches; no logic clocked on SCLK.

Verification
REQ-032 After reset, two frames with cmd ch=3 then ch=5, smpl=12'hABC for both -> frame 1 ch_req with chnl=3; frame 2 MISO reads 16'h0ABC; chnl=5.
REQ-033 SS_n raised after 9 SCLKs with cmd ch=6 -> frm_err single pulse; chnl keeps its prior value; no ch_req.
REQ-034 20 SCLKs in one frame, cmd ch=2, smpl=12'hFFF -> MISO 16'h0FFF, then 0 for 4 bits; chnl=2; no error.
REQ-035 rst asserted at bit 8 of a ch=7 frame, released while SS_n low -> no ch_req or frm_err; next full frame with ch=1 -> chnl=1.
REQ-036 Command 16'hC7FF (don't-care bits set, ch=0) -> chnl=0, ch_req pulses once.
REQ-037 Back-to-back frames with 2-clk SS_n high gap, ch=4 then ch=6 -> both latched in order; ch_req pulses exactly twice.
